fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 8-bit sync FIFO between NUM_REQ producers.
//  Round-robin arbitration with bounded bursts; backpressure taken from FIFO full.
//  Sits directly in front of fifo.w_en/data_in; read side of the FIFO untouched.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  DATA_W     8   word width, equals FIFO data width
//  MAX_BURST  4   max consecutive words accepted from one requester per grant (1..16)
// PORTS
//  clk           in   1               single clock, all state on posedge
//  rst_n         in   1               asynchronous, active-low reset
//  req_valid     in   NUM_REQ         requester i has a word on req_data slice i
//  req_data      in   NUM_REQ*DATA_W  slice i = bits [i*DATA_W +: DATA_W]
//  req_ready     out  NUM_REQ         one-hot; word of requester i accepted this cycle
//  fifo_full     in   1               FIFO full flag
//  fifo_w_en     out  1               FIFO write enable
//  fifo_data_in  out  DATA_W          FIFO write data
//  busy          out  1               high while in BURST
//  grant_idx     out  IDX_W           index of current grantee (IDX_W=$clog2(NUM_REQ))
// BEHAVIOUR
//  Reset (async): state=IDLE, grant_idx=0, last_grant=NUM_REQ-1, burst_cnt=0;
//   hence req_ready=0, fifo_w_en=0, fifo_data_in=0, busy=0.
//  States: IDLE, BURST. grant_idx, burst_cnt, last_grant registered.
//  IDLE: any req_valid -> BURST, grant_idx = first valid searching last_grant+1
//   upward with wrap (NUM_REQ-1 -> 0); burst_cnt=0. No transfer in IDLE (1-cycle arb bubble).
//  BURST, g=grant_idx: xfer = req_valid[g] & ~fifo_full (combinational, zero latency):
//   fifo_w_en=xfer; fifo_data_in=req_data slice g (0 when not BURST); req_ready=xfer<<g.
//  xfer & burst_cnt==MAX_BURST-1, or ~req_valid[g]: burst ends, last_grant=g;
//   same-cycle re-arbitration over current req_valid from g+1 with wrap:
//   hit -> BURST with new grant, burst_cnt=0 (no bubble); none -> IDLE.
//   g itself is eligible last, so a lone requester is re-granted immediately.
//  xfer otherwise: burst_cnt+1. fifo_full stall: no xfer, burst_cnt/grant hold; no timeout.
//  Requester contract: req_valid/req_data held stable until req_ready; the arbiter
//   never drops a valid word; a requester dropping valid before ready forfeits its grant.
//  fifo_full & ~req_valid[g] same cycle: burst ends (valid loss wins).
//  Reset mid-burst: immediate return to reset values; partial burst not resumed.
//  burst_cnt width $clog2(MAX_BURST)+1; never exceeds MAX_BURST-1.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: extra output word_cnt [NUM_REQ*16] out; slice i counts
//   accepted words of requester i, +1 per req_ready[i], saturates at 16'hFFFF,
//   cleared by rst_n only.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  fifo_arb_pkg: state encodings (IDLE=1'b0, BURST=1'b1), IDX_W derivation function,
//   stats counter width 16, saturation constant.
//  Sub-module rr_pick: combinational round-robin picker (req vector, last index ->
//   found, index); instantiated once, shared by IDLE and burst-end paths.
// TESTING (20 ns clock, rst_n released at 50 ns, as in existing FIFO bench)
//  Single requester: req_valid=4'b0001, data 10,20,30,40,50 -> grant after 1 bubble;
//   bursts of 4 then immediate regrant; FIFO holds 10..50 in order, no gaps after first.
//  Fairness: all 4 valid continuously -> grant order 0,1,2,3,0 with 4 words each;
//   req_ready always one-hot.
//  Backpressure: fifo_full forced high 3 cycles mid-burst -> fifo_w_en=0, data held,
//   burst resumes with burst_cnt unchanged; no word lost or duplicated.
//  Early release: req 2 drops valid after 2 words while req 3 pending -> grant moves
//   to 3 same cycle, last_grant=2.
//  Reset mid-burst: rst_n low at burst word 2 -> outputs 0 asynchronously; after
//   release, requester 0 wins first arbitration.
//  Stats (FIFO_ARB_STATS_EN): 6 words req 1 -> word_cnt slice1=6; preload near
//   16'hFFFF -> holds at 16'hFFFF.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// FSM state encodings, grant index width helper and stats counter constants.
// The stats constants are used only when FIFO_ARB_STATS_EN is defined.
package fifo_arb_pkg;

  // Arbiter states: IDLE waits for any requester, BURST owns the FIFO write port.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Per-requester accepted-word counter width and saturation value.
  localparam int                STATS_W   = 16;
  localparam logic [STATS_W-1:0] STATS_SAT = 16'hFFFF;

  // Width of a requester index. At least one bit, so that a 2-requester
  // build still has a usable grant_idx.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The search starts at i_last+1 and moves upward, wrapping from NUM_REQ-1 to 0.
// i_last itself is examined last, so a lone requester can win again.
// o_found is low when no request bit is set; o_idx is then 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // Take the first set request bit after i_last, in wrapped order.
  always_comb begin
    logic             found_v;
    logic [IDX_W-1:0] idx_v;
    logic             take_v;
    int               j;
    found_v = 1'b0;
    idx_v   = '0;
    take_v  = 1'b0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j       = (int'(i_last) + k) % NUM_REQ;
      take_v  = i_req[j] & ~found_v;
      idx_v   = take_v ? IDX_W'(j) : idx_v;
      found_v = found_v | take_v;
    end
    o_found = found_v;
    o_idx   = idx_v;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single write port of the sync FIFO
// between NUM_REQ producers.
// A grant covers a burst of at most MAX_BURST words, and backpressure comes
// from fifo_full. The transfer handshake is combinational, with zero latency.
// When one burst ends, the next grantee is chosen in the same cycle, so no
// bubble appears. The only bubble is the single arbitration cycle spent
// leaving IDLE.
// Optional feature: define FIFO_ARB_STATS_EN to add the word_cnt output,
// which holds saturating accepted-word counters, one per requester.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_w_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_idx
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] word_cnt
`endif
);

  localparam int                BCNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_RST   = IDX_W'(NUM_REQ - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_grant_idx;
  logic [IDX_W-1:0]  w_grant_nxt;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  w_last_nxt;
  logic [BCNT_W-1:0] r_burst_cnt;
  logic [BCNT_W-1:0] w_cnt_nxt;

  logic              w_cur_valid;
  logic [DATA_W-1:0] w_cur_data;
  logic              w_xfer;
  logic [IDX_W-1:0]  w_pick_last;
  logic              w_pick_found;
  logic [IDX_W-1:0]  w_pick_idx;

  // In IDLE the search restarts after the last grantee. At the end of a burst
  // it starts after the current grantee, which then becomes last_grant.
  assign w_pick_last = (r_state == ST_BURST) ? r_grant_idx : r_last_grant;

  // One picker serves both the IDLE path and the burst-end path.
  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_last  (w_pick_last),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // Select the valid bit and data slice that belong to the current grantee.
  always_comb begin
    logic hit_v;
    hit_v       = 1'b0;
    w_cur_valid = 1'b0;
    w_cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_v       = (r_grant_idx == IDX_W'(i));
      w_cur_valid = w_cur_valid | (req_valid[i] & hit_v);
      w_cur_data  = w_cur_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{hit_v}});
    end
  end

  // State register. Reset leaves last_grant at the top index, so requester 0
  // wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= LAST_RST;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_idx  <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
    end
  end

  // Next-state logic and the zero-latency write handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant_idx;
    w_last_nxt   = r_last_grant;
    w_cnt_nxt    = r_burst_cnt;
    w_xfer       = 1'b0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: begin
        // The arbitration bubble: no transfer happens in this state.
        if (w_pick_found) begin
          w_state_nxt = ST_BURST;
          w_grant_nxt = w_pick_idx;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        w_xfer       = w_cur_valid & ~fifo_full;
        fifo_w_en    = w_xfer;
        fifo_data_in = w_cur_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = w_xfer & (r_grant_idx == IDX_W'(i));
        end
        // Loss of valid takes priority over a stall caused by fifo_full.
        if (!w_cur_valid || (w_xfer && (r_burst_cnt == BURST_LAST))) begin
          w_last_nxt = r_grant_idx;
          w_cnt_nxt  = '0;
          if (w_pick_found) begin
            w_state_nxt = ST_BURST;
            w_grant_nxt = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_burst_cnt + BCNT_W'(1);
        end else begin
          // Stalled by fifo_full: hold the grant and the count. No timeout.
          w_cnt_nxt = r_burst_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_last_nxt  = LAST_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = (r_state == ST_BURST);
  assign grant_idx = r_grant_idx;

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [STATS_W-1:0] r_cnt;

    // Count accepted words for this requester and saturate at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (req_ready[gi] && (r_cnt != STATS_SAT)) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end

    assign word_cnt[gi*STATS_W +: STATS_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// Directed scenarios and randomized traffic are compared every cycle against
// a behavioural round-robin model.
// Define FIFO_ARB_STATS_EN to also check the word_cnt output.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int IDX_W     = 2;

  logic                      clk = 1'b1;
  logic                      rst_n = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full = 1'b0;
  logic                      fifo_w_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      busy;
  logic [IDX_W-1:0]          grant_idx;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     word_cnt;
`endif

  always #10 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .busy         (busy),
    .grant_idx    (grant_idx)
`ifdef FIFO_ARB_STATS_EN
    ,
    .word_cnt     (word_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Producer side: one queue of pending words per requester, plus a drop mask
  // that lets a requester withdraw its valid.
  logic [DATA_W-1:0] q [NUM_REQ][$];
  bit                drop [NUM_REQ];
  bit                tb_full = 1'b0;

  // Words accepted by the DUT, as observed on the FIFO side.
  logic [DATA_W-1:0] acc_data [$];
  int                acc_grant [$];
  int                acc_cyc [$];

  // Reference model: busy flag, grantee, previous grantee, words taken in the
  // current burst, and the total words accepted per requester.
  bit m_busy;
  int m_grant;
  int m_last;
  int m_cnt;
  int m_words [NUM_REQ];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // First requester after 'from', searching upward with wrap; -1 if none.
  function automatic int rr_next(input logic [NUM_REQ-1:0] v, input int from);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(from + k) % NUM_REQ]) return (from + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (q[i].size() > 0) && !drop[i];
      req_data[i*DATA_W +: DATA_W] = (q[i].size() > 0) ? q[i][0] : DATA_W'($urandom_range(255, 0));
    end
    fifo_full = tb_full;
  endtask

  task automatic clear_log();
    acc_data.delete();
    acc_grant.delete();
    acc_cyc.delete();
  endtask

  // One clock cycle. It is entered just after a rising edge. Outputs are
  // checked mid-cycle, then the model and the producers advance to the next edge.
  task automatic cycle();
    logic [NUM_REQ-1:0] v;
    logic [31:0]        exp_ready;
    logic [DATA_W-1:0]  exp_data;
    bit                 xfer;
    int                 nxt;
    apply_inputs();
    v = req_valid;
    #5;
    xfer      = m_busy && v[m_grant] && !tb_full;
    exp_ready = xfer ? (32'd1 << m_grant) : 32'd0;
    exp_data  = m_busy ? req_data[m_grant*DATA_W +: DATA_W] : '0;
    check_eq("busy", {31'd0, busy}, {31'd0, m_busy});
    check_eq("grant_idx", {30'd0, grant_idx}, m_grant);
    check_eq("fifo_w_en", {31'd0, fifo_w_en}, {31'd0, xfer});
    check_eq("req_ready", {28'd0, req_ready}, exp_ready);
    check_eq("fifo_data_in", {24'd0, fifo_data_in}, {24'd0, exp_data});
    check_eq("ready_onehot", {31'd0, ($countones(req_ready) <= 1)}, 32'd1);
    if (fifo_w_en === 1'b1) begin
      acc_data.push_back(fifo_data_in);
      acc_grant.push_back(int'(grant_idx));
      acc_cyc.push_back(cyc);
    end
    if (xfer) begin
      void'(q[m_grant].pop_front());
      m_words[m_grant]++;
    end
    if (!m_busy) begin
      nxt = rr_next(v, m_last);
      if (nxt >= 0) begin
        m_busy  = 1'b1;
        m_grant = nxt;
        m_cnt   = 0;
      end
    end else if ((xfer && m_cnt == MAX_BURST - 1) || !v[m_grant]) begin
      m_last = m_grant;
      m_cnt  = 0;
      nxt    = rr_next(v, m_grant);
      if (nxt >= 0) m_grant = nxt;
      else m_busy = 1'b0;
    end else if (xfer) begin
      m_cnt++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously and check the outputs at once. The reset is
  // then held across a rising edge and released in the middle of a cycle.
  task automatic pulse_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      q[i].delete();
      drop[i]    = 1'b0;
      m_words[i] = 0;
    end
    tb_full = 1'b0;
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_grant", {30'd0, grant_idx}, 32'd0);
    check_eq("rst_w_en", {31'd0, fifo_w_en}, 32'd0);
    check_eq("rst_ready", {28'd0, req_ready}, 32'd0);
    check_eq("rst_data", {24'd0, fifo_data_in}, 32'd0);
    m_busy  = 1'b0;
    m_grant = 0;
    m_last  = NUM_REQ - 1;
    m_cnt   = 0;
    apply_inputs();
    for (int k = 0; k < 3; k++) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    logic [DATA_W-1:0] words [$];

    // Reset is released at 50 ns.
    pulse_reset();

    // A single requester sends 10..50: one bubble, a burst of 4, an immediate
    // regrant, and no gaps between words.
    clear_log();
    for (int k = 1; k <= 5; k++) q[0].push_back(DATA_W'(10 * k));
    c0 = cyc;
    for (int k = 0; k < 8; k++) cycle();
    check_eq("single_cnt", acc_data.size(), 32'd5);
    for (int k = 0; k < acc_data.size(); k++) begin
      check_eq("single_data", {24'd0, acc_data[k]}, 10 * (k + 1));
      check_eq("single_gap", acc_cyc[k], c0 + 1 + k);
    end

    // Fairness: all four requesters stay valid and are granted in the order
    // 0,1,2,3,0 with 4 words each.
    pulse_reset();
    clear_log();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(DATA_W'($urandom_range(255, 0)));
    for (int k = 0; k < 21; k++) cycle();
    check_eq("fair_cnt", acc_grant.size(), 32'd20);
    for (int k = 0; k < 20 && k < acc_grant.size(); k++)
      check_eq("fair_order", acc_grant[k], (k / 4) % NUM_REQ);

    // Backpressure: fifo_full is held high for 3 cycles in the middle of a
    // burst. No word may be lost or duplicated.
    pulse_reset();
    clear_log();
    words.delete();
    for (int k = 0; k < 6; k++) words.push_back(DATA_W'($urandom_range(255, 0)));
    for (int k = 0; k < 6; k++) q[0].push_back(words[k]);
    for (int k = 0; k < 12; k++) begin
      tb_full = (k >= 3 && k <= 5);
      cycle();
    end
    tb_full = 1'b0;
    check_eq("bp_cnt", acc_data.size(), 32'd6);
    for (int k = 0; k < 6 && k < acc_data.size(); k++)
      check_eq("bp_data", {24'd0, acc_data[k]}, {24'd0, words[k]});

    // Early release: requester 2 drops valid after 2 words, and the grant
    // moves to 3 in the same cycle. After 3's burst, 2 wins again.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      q[2].push_back(DATA_W'($urandom_range(255, 0)));
      q[3].push_back(DATA_W'($urandom_range(255, 0)));
    end
    for (int k = 0; k < 12; k++) begin
      drop[2] = (k == 3);
      cycle();
      if (k == 3) begin
        check_eq("early_grant", {30'd0, grant_idx}, 32'd3);
        check_eq("early_busy", {31'd0, busy}, 32'd1);
      end
      if (k == 7) check_eq("rearb_after_3", {30'd0, grant_idx}, 32'd2);
    end

    // Reset during the second word of a burst, then requester 0 wins first.
    pulse_reset();
    for (int k = 0; k < 6; k++) q[0].push_back(DATA_W'($urandom_range(255, 0)));
    for (int k = 0; k < 4; k++) q[2].push_back(DATA_W'($urandom_range(255, 0)));
    cycle();
    cycle();
    apply_inputs();
    #2;
    check_eq("pre_rst_wen", {31'd0, fifo_w_en}, 32'd1);
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      q[0].push_back(DATA_W'($urandom_range(255, 0)));
      q[2].push_back(DATA_W'($urandom_range(255, 0)));
    end
    cycle();
    check_eq("post_rst_grant", {30'd0, grant_idx}, 32'd0);
    for (int k = 0; k < 6; k++) cycle();

    // Randomized traffic: bursty producers, occasional valid drops and random
    // fifo_full.
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() == 0 && $urandom_range(2, 0) == 0)
          for (int k = 0; k < int'($urandom_range(6, 1)); k++)
            q[i].push_back(DATA_W'($urandom_range(255, 0)));
        drop[i] = ($urandom_range(15, 0) == 0);
      end
      tb_full = ($urandom_range(3, 0) == 0);
      cycle();
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++)
      check_eq("word_cnt", {16'd0, word_cnt[i*16 +: 16]}, m_words[i]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
